// File: rtl/ase_hssi_pkt_gen_pkg.sv
// Shared types and helpers for the AFU-side HSSI packet generator.
//   t_pkt_gen_state : generator FSM states
//   t_hssi_pkt_hdr  : low 64 bits of a header beat {seq, len, magic}
//   next_lfsr()     : one step of the payload Galois LFSR
package ase_hssi_pkt_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_GAP,
        ST_DONE
    } t_pkt_gen_state;

    typedef struct packed {
        logic [31:0] seq;
        logic [15:0] len;
        logic [15:0] magic;
    } t_hssi_pkt_hdr;

    localparam logic [15:0] HSSI_PKT_MAGIC     = 16'hA5E5;
    localparam logic [31:0] HSSI_PKT_LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois form: the bit shifted out selects the feedback.
    function automatic logic [31:0] next_lfsr(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ HSSI_PKT_LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/hssi_pkt_lfsr.sv
// 32-bit payload LFSR for the HSSI packet generator.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load, seed : load seed (zero seed is replaced by 1, the all-zero state locks up)
//   adv        : advance one step (load wins when both are set)
//   state      : current LFSR value
module hssi_pkt_lfsr
    import ase_hssi_pkt_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= 32'h1;
        end else if (load) begin
            state <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (adv) begin
            state <= next_lfsr(state);
        end
    end

endmodule

// File: rtl/ase_hssi_afu_pkt_gen.sv
// AFU-side HSSI traffic source. Sends pkt_count framed packets (header beat followed by
// LFSR payload beats) on an AXI-S TX interface, honouring tready back-pressure.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : pulse, begins a run (only looked at in IDLE)
//   pkt_count, pkt_len_bytes, seed : run configuration, captured at start
//   busy, done            : run in progress / one-cycle end-of-run pulse
//   tx_*                  : AXI-S master (tuser is always zero)
//   pkts_sent, beats_sent : accepted packets / beats in the current or last run
//   pause                 : only with HSSI_PKT_GEN_PAUSE_EN defined; holds off the next header
// Build option: define HSSI_PKT_GEN_PAUSE_EN to add the pause input.
//
// state   | meaning
// IDLE    | waiting for start
// HDR     | header beat pending (tvalid may be held low by pause)
// PAY     | payload beats of the current packet
// GAP     | inter-packet idle cycles
// DONE    | end of run, done pulse
module ase_hssi_afu_pkt_gen
    import ase_hssi_pkt_gen_pkg::*;
#(
    parameter int TDATA_WIDTH   = 64,
    parameter int TKEEP_WIDTH   = TDATA_WIDTH / 8,
    parameter int TUSER_WIDTH   = 1,
    parameter int MAX_LEN_BYTES = 9600,
    parameter int IPG_CYCLES    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            pkt_count,
    input  logic [15:0]            pkt_len_bytes,
    input  logic [31:0]            seed,
    output logic                   busy,
    output logic                   done,
    output logic                   tx_tvalid,
    input  logic                   tx_tready,
    output logic [TDATA_WIDTH-1:0] tx_tdata,
    output logic [TKEEP_WIDTH-1:0] tx_tkeep,
    output logic                   tx_tlast,
    output logic [TUSER_WIDTH-1:0] tx_tuser,
    output logic [31:0]            pkts_sent,
    output logic [31:0]            beats_sent
`ifdef HSSI_PKT_GEN_PAUSE_EN
    ,
    input  logic                   pause
`endif
);

    localparam int REPS = TDATA_WIDTH / 32;

    t_pkt_gen_state state;
    logic [31:0]    cfg_count;
    logic [15:0]    cfg_len;
    logic [15:0]    cfg_beats;
    logic [15:0]    beat_idx;
    logic [31:0]    seq;
    logic [15:0]    gap_cnt;
    logic [31:0]    lfsr_q;
    logic           pause_i;

`ifdef HSSI_PKT_GEN_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign tx_tuser = '0;

    logic accept;
    logic run_start;
    assign accept    = tx_tvalid && tx_tready;
    assign run_start = (state == ST_IDLE) && start;

    hssi_pkt_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (run_start),
        .seed  (seed),
        .adv   (accept),
        .state (lfsr_q)
    );

    // The output beat is a register, so the beat that will be presented after this edge
    // is built from the post-edge values of the sequencing state.
    logic [15:0]            start_len;
    logic [15:0]            start_beats;
    logic [16:0]            len_round;
    logic [15:0]            nxt_len;
    logic [15:0]            nxt_beats;
    logic [15:0]            nxt_beat;
    logic [31:0]            nxt_seq;
    logic [31:0]            nxt_lfsr;
    logic [15:0]            len_rem;
    logic [TKEEP_WIDTH-1:0] last_keep;
    logic [TDATA_WIDTH-1:0] beat_data;
    logic [TKEEP_WIDTH-1:0] beat_keep;
    logic                   beat_last;
    logic                   load_beat;
    t_hssi_pkt_hdr          hdr;

    always_comb begin
        if (pkt_len_bytes < 16'(TKEEP_WIDTH)) begin
            start_len = 16'(TKEEP_WIDTH);
        end else if (pkt_len_bytes > 16'(MAX_LEN_BYTES)) begin
            start_len = 16'(MAX_LEN_BYTES);
        end else begin
            start_len = pkt_len_bytes;
        end
        len_round   = {1'b0, start_len} + 17'(TKEEP_WIDTH - 1);
        start_beats = 16'(len_round / 17'(TKEEP_WIDTH));

        nxt_len   = run_start ? start_len : cfg_len;
        nxt_beats = run_start ? start_beats : cfg_beats;
        if (run_start) begin
            nxt_beat = 16'h0;
            nxt_seq  = 32'h0;
            nxt_lfsr = (seed == 32'h0) ? 32'h1 : seed;
        end else begin
            nxt_beat = accept ? (tx_tlast ? 16'h0 : beat_idx + 16'h1) : beat_idx;
            nxt_seq  = (accept && tx_tlast) ? seq + 32'h1 : seq;
            nxt_lfsr = accept ? next_lfsr(lfsr_q) : lfsr_q;
        end

        len_rem = nxt_len % 16'(TKEEP_WIDTH);
        for (int i = 0; i < TKEEP_WIDTH; i++) begin
            last_keep[i] = (len_rem == 16'h0) || (16'(i) < len_rem);
        end
        beat_last = (nxt_beat == nxt_beats - 16'h1);
        beat_keep = beat_last ? last_keep : '1;

        hdr.seq   = nxt_seq;
        hdr.len   = nxt_len;
        hdr.magic = HSSI_PKT_MAGIC;
        beat_data = {REPS{nxt_lfsr}};
        if (nxt_beat == 16'h0) begin
            beat_data[63:0] = hdr;
        end

        // Reloading only when nothing is offered or the beat was taken keeps the
        // presented beat frozen across tready stalls.
        load_beat = run_start ||
                    (((state == ST_HDR) || (state == ST_PAY) || (state == ST_GAP)) &&
                     (!tx_tvalid || accept));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            tx_tvalid  <= 1'b0;
            tx_tdata   <= '0;
            tx_tkeep   <= '0;
            tx_tlast   <= 1'b0;
            pkts_sent  <= '0;
            beats_sent <= '0;
            cfg_count  <= '0;
            cfg_len    <= '0;
            cfg_beats  <= '0;
            beat_idx   <= '0;
            seq        <= '0;
            gap_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (load_beat) begin
                tx_tdata <= beat_data;
                tx_tkeep <= beat_keep;
                tx_tlast <= beat_last;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_count  <= pkt_count;
                        cfg_len    <= start_len;
                        cfg_beats  <= start_beats;
                        beat_idx   <= '0;
                        seq        <= '0;
                        pkts_sent  <= '0;
                        beats_sent <= '0;
                        busy       <= 1'b1;
                        if (pkt_count == 32'h0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_HDR;
                            tx_tvalid <= !pause_i;
                        end
                    end
                end
                ST_HDR, ST_PAY: begin
                    if (!tx_tvalid) begin
                        if (!pause_i) begin
                            tx_tvalid <= 1'b1;
                        end
                    end else if (accept) begin
                        beats_sent <= beats_sent + 32'h1;
                        beat_idx   <= nxt_beat;
                        seq        <= nxt_seq;
                        if (!tx_tlast) begin
                            state <= ST_PAY;
                        end else begin
                            pkts_sent <= pkts_sent + 32'h1;
                            if (pkts_sent + 32'h1 == cfg_count) begin
                                state     <= ST_DONE;
                                done      <= 1'b1;
                                tx_tvalid <= 1'b0;
                            end else if (IPG_CYCLES == 0) begin
                                state     <= ST_HDR;
                                tx_tvalid <= !pause_i;
                            end else begin
                                state     <= ST_GAP;
                                tx_tvalid <= 1'b0;
                                gap_cnt   <= 16'(IPG_CYCLES - 1);
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 16'h0) begin
                        state     <= ST_HDR;
                        tx_tvalid <= !pause_i;
                    end else begin
                        gap_cnt <= gap_cnt - 16'h1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ase_hssi_afu_pkt_gen.sv
module tb_ase_hssi_afu_pkt_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pkt_count;
    logic [15:0] pkt_len_bytes;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic        tx_tvalid;
    logic        tx_tready = 1'b1;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic        tx_tlast;
    logic [0:0]  tx_tuser;
    logic [31:0] pkts_sent;
    logic [31:0] beats_sent;
`ifdef HSSI_PKT_GEN_PAUSE_EN
    logic        pause;
`endif

    ase_hssi_afu_pkt_gen #(
        .TDATA_WIDTH   (64),
        .TKEEP_WIDTH   (8),
        .TUSER_WIDTH   (1),
        .MAX_LEN_BYTES (9600),
        .IPG_CYCLES    (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pkt_count     (pkt_count),
        .pkt_len_bytes (pkt_len_bytes),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .tx_tvalid     (tx_tvalid),
        .tx_tready     (tx_tready),
        .tx_tdata      (tx_tdata),
        .tx_tkeep      (tx_tkeep),
        .tx_tlast      (tx_tlast),
        .tx_tuser      (tx_tuser),
        .pkts_sent     (pkts_sent),
        .beats_sent    (beats_sent)
`ifdef HSSI_PKT_GEN_PAUSE_EN
        ,
        .pause         (pause)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] q_data[$];
    logic [7:0]  q_keep[$];
    logic        q_last[$];
    bit          valid_seen = 1'b0;
    bit          rand_ready = 1'b0;

    // tready changes 1 time unit after the rising edge and is held until the next one.
    always @(posedge clk) begin
        #1;
        tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Beat monitor on the falling edge: records accepted beats and checks that a
    // stalled beat is held unchanged into the next cycle.
    bit          stall_prev = 1'b0;
    logic [63:0] d_prev;
    logic [7:0]  k_prev;
    logic        l_prev;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (tx_tvalid) valid_seen = 1'b1;
            if (stall_prev) begin
                checks++;
                if (tx_tvalid !== 1'b1 || tx_tdata !== d_prev || tx_tkeep !== k_prev ||
                    tx_tlast !== l_prev) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b, want v=1 d=%h k=%h l=%b",
                             tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, d_prev, k_prev, l_prev);
                end
            end
            if (tx_tvalid && tx_tready) begin
                q_data.push_back(tx_tdata);
                q_keep.push_back(tx_tkeep);
                q_last.push_back(tx_tlast);
            end
            stall_prev = tx_tvalid && !tx_tready;
            d_prev = tx_tdata;
            k_prev = tx_tkeep;
            l_prev = tx_tlast;
        end
    end

    function automatic logic [31:0] model_lfsr(input logic [31:0] s);
        logic [31:0] fb;
        fb = s[0] ? 32'h8020_0003 : 32'h0;
        return {1'b0, s[31:1]} ^ fb;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        valid_seen = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        pkt_count = 32'd0;
        pkt_len_bytes = 16'd0;
        seed = 32'd0;
`ifdef HSSI_PKT_GEN_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) step();
        checks++;
        if ({busy, done, tx_tvalid, tx_tlast} !== 4'b0 || tx_tdata !== 64'h0 || tx_tkeep !== 8'h0 ||
            pkts_sent !== 32'h0 || beats_sent !== 32'h0 || tx_tuser !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b v=%b last=%b d=%h k=%h pk=%0d bt=%0d, want all 0",
                     busy, done, tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, pkts_sent, beats_sent);
        end
        reset = 1'b0;
        repeat (2) step();
        checks++;
        if (busy !== 1'b0 || tx_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b v=%b, want 0 0", busy, tx_tvalid);
        end
    endtask

    // One run; the config inputs are scrambled right after start and a second start
    // is pulsed mid-run, both must have no effect.
    task automatic test_traffic(input string name, input logic [31:0] cnt, input logic [15:0] len,
                                input logic [31:0] sd, input bit rnd,
                                input logic [15:0] exp_len, input int exp_beats,
                                input logic [7:0] exp_lastkeep);
        logic [31:0] mlfsr;
        logic [63:0] exp_d;
        logic [7:0]  exp_k;
        logic        exp_l;
        int          idx;
        clear_mon();
        rand_ready = rnd;
        pkt_count = cnt;
        pkt_len_bytes = len;
        seed = sd;
        start = 1'b1;
        step();
        start = 1'b0;
        pkt_count = 32'd99;
        pkt_len_bytes = 16'd5;
        seed = 32'hDEAD_0001;
        checks++;
        if (busy !== 1'b1 || tx_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got busy=%b v=%b one cycle after start, want 1 1", name, busy, tx_tvalid);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: got done=%b, want 1 within 4000 cycles", name, done);
        end
        checks++;
        if (pkts_sent !== cnt || beats_sent !== cnt * 32'(exp_beats)) begin
            errors++;
            $display("FAIL %s counters: got pkts=%0d beats=%0d, want pkts=%0d beats=%0d",
                     name, pkts_sent, beats_sent, cnt, cnt * 32'(exp_beats));
        end
        rand_ready = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pkts_sent !== cnt) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b pkts=%0d, want 0 0 %0d",
                     name, done, busy, pkts_sent, cnt);
        end
        checks++;
        if (q_data.size() !== int'(cnt) * exp_beats) begin
            errors++;
            $display("FAIL %s beat_count: got %0d, want %0d", name, q_data.size(), int'(cnt) * exp_beats);
        end else begin
            mlfsr = (sd == 32'h0) ? 32'h1 : sd;
            idx = 0;
            for (int p = 0; p < int'(cnt); p++) begin
                for (int b = 0; b < exp_beats; b++) begin
                    exp_l = (b == exp_beats - 1);
                    exp_k = exp_l ? exp_lastkeep : 8'hFF;
                    exp_d = (b == 0) ? {32'(p), exp_len, 16'hA5E5} : {mlfsr, mlfsr};
                    checks++;
                    if (q_last[idx] !== exp_l || q_keep[idx] !== exp_k) begin
                        errors++;
                        $display("FAIL %s framing pkt%0d beat%0d: got last=%b keep=%h, want last=%b keep=%h",
                                 name, p, b, q_last[idx], q_keep[idx], exp_l, exp_k);
                    end
                    checks++;
                    if (q_data[idx] !== exp_d) begin
                        errors++;
                        $display("FAIL %s data pkt%0d beat%0d: got %h, want %h", name, p, b, q_data[idx], exp_d);
                    end
                    mlfsr = model_lfsr(mlfsr);
                    idx++;
                end
            end
        end
    endtask

    task automatic test_zero_count();
        clear_mon();
        pkt_count = 32'd0;
        pkt_len_bytes = 16'd64;
        seed = 32'h1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || tx_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_count_done: got done=%b v=%b, want 1 0", done, tx_tvalid);
        end
        repeat (3) step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || valid_seen !== 1'b0 || beats_sent !== 32'h0) begin
            errors++;
            $display("FAIL zero_count_idle: got done=%b busy=%b valid_seen=%b beats=%0d, want 0 0 0 0",
                     done, busy, valid_seen, beats_sent);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        pkt_count = 32'd3;
        pkt_len_bytes = 16'd64;
        seed = 32'h0BAD_F00D;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 100 && q_data.size() < 4; c++) step();
        checks++;
        if (q_data.size() !== 4) begin
            errors++;
            $display("FAIL mid_reset_reach: got %0d beats, want 4", q_data.size());
        end
        reset = 1'b1;
        step();
        checks++;
        if (tx_tvalid !== 1'b0 || busy !== 1'b0 || pkts_sent !== 32'h0 || beats_sent !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_state: got v=%b busy=%b pkts=%0d beats=%0d, want 0 0 0 0",
                     tx_tvalid, busy, pkts_sent, beats_sent);
        end
        reset = 1'b0;
        step();
        test_traffic("restart", 32'd1, 16'd64, 32'h0BAD_F00D, 1'b0, 16'd64, 8, 8'hFF);
    endtask

`ifdef HSSI_PKT_GEN_PAUSE_EN
    task automatic test_pause();
        clear_mon();
        pause = 1'b0;
        pkt_count = 32'd2;
        pkt_len_bytes = 16'd64;
        seed = 32'h1357_9BDF;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 100 && q_data.size() < 3; c++) step();
        pause = 1'b1;
        for (int c = 0; c < 100 && q_data.size() < 8; c++) step();
        repeat (10) step();
        checks++;
        if (q_data.size() !== 8 || tx_tvalid !== 1'b0 || q_last[7] !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold: got beats=%0d v=%b, want beats=8 v=0 with pkt 1 complete",
                     q_data.size(), tx_tvalid);
        end
        pause = 1'b0;
        step();
        checks++;
        if (tx_tvalid !== 1'b1 || tx_tdata[31:0] !== 32'h0040_A5E5 || tx_tdata[63:32] !== 32'h1) begin
            errors++;
            $display("FAIL pause_release: got v=%b d=%h, want v=1 header seq 1 len 64", tx_tvalid, tx_tdata);
        end
        for (int c = 0; c < 100 && !done; c++) step();
        checks++;
        if (done !== 1'b1 || q_data.size() !== 16) begin
            errors++;
            $display("FAIL pause_finish: got done=%b beats=%0d, want 1 16", done, q_data.size());
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_traffic("len64_cnt3", 32'd3, 16'd64, 32'h1234_5678, 1'b0, 16'd64, 8, 8'hFF);
        test_traffic("len70", 32'd1, 16'd70, 32'h0, 1'b0, 16'd70, 9, 8'h3F);
        test_traffic("len5_clamp", 32'd1, 16'd5, 32'hFFFF_FFFF, 1'b0, 16'd8, 1, 8'hFF);
        test_traffic("backpressure", 32'd20, 16'd20, 32'hCAFE_BABE, 1'b1, 16'd20, 3, 8'h0F);
        test_zero_count();
        test_reset_mid();
`ifdef HSSI_PKT_GEN_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
